floo_link_boundary: RTL and testbench

Parametrised tile-edge link stage: it sits between a tile's NoC router ports and the inter-tile wires. It replaces fixed per-direction output delays with a registered FIFO buffer per port, plus a per-port isolation handshake for safe tile power-down. It also keeps a per-port forwarded-flit counter. One instance serves one physical channel class (req, rsp or wide); a tile instantiates one per class.

---
 rtl/floo_link_boundary_pkg.sv | 18 +
 rtl/floo_link_boundary_if.sv | 29 ++
 rtl/floo_link_port.sv | 107 ++++++++++
 rtl/floo_link_boundary.sv | 50 +++++
 tb/tb_floo_link_boundary.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/floo_link_boundary_pkg.sv
// Shared types and limits for the tile-edge link boundary stage.
// Port FSM states and the legal FIFO depth range live here.
package floo_link_boundary_pkg;

  localparam int unsigned MinLinkDepth = 2;
  localparam int unsigned MaxLinkDepth = 16;

  typedef enum logic [1:0] {
    StActive,
    StDrain,
    StIsolated
  } port_state_e;

  function automatic logic depth_ok(input int unsigned depth);
    return (depth >= MinLinkDepth) && (depth <= MaxLinkDepth);
  endfunction

endpackage

// File: rtl/floo_link_boundary_if.sv
// Router-side and link-side handshake bundle for all ports of one channel class.
// master = router/link environment, slave = the boundary stage.
interface floo_link_boundary_if #(
  parameter int unsigned NumPorts  = 4,
  parameter int unsigned FlitWidth = 64,
  parameter int unsigned CntWidth  = 16
);

  logic [NumPorts-1:0]           in_valid_i;
  logic [NumPorts-1:0]           in_ready_o;
  logic [NumPorts*FlitWidth-1:0] in_data_i;
  logic [NumPorts-1:0]           out_valid_o;
  logic [NumPorts-1:0]           out_ready_i;
  logic [NumPorts*FlitWidth-1:0] out_data_o;
  logic [NumPorts-1:0]           isolate_req_i;
  logic [NumPorts-1:0]           isolate_ack_o;
  logic [NumPorts*CntWidth-1:0]  fwd_cnt_o;

  modport master (
    output in_valid_i, in_data_i, out_ready_i, isolate_req_i,
    input  in_ready_o, out_valid_o, out_data_o, isolate_ack_o, fwd_cnt_o
  );

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i, isolate_req_i,
    output in_ready_o, out_valid_o, out_data_o, isolate_ack_o, fwd_cnt_o
  );

endinterface

// File: rtl/floo_link_port.sv
// One link port: registered FIFO, isolation FSM and forwarded-flit counter.
// All handshake outputs are registered, so in_ready_o never sees out_ready_i.
module floo_link_port
  import floo_link_boundary_pkg::*;
#(
  parameter int unsigned FlitWidth = 64,
  parameter int unsigned Depth     = 2,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [FlitWidth-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [FlitWidth-1:0] out_data_o,
  input  logic                 isolate_req_i,
  output logic                 isolate_ack_o,
  output logic [CntWidth-1:0]  fwd_cnt_o
);

  localparam int unsigned PtrWidth  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned FillWidth = $clog2(Depth + 1);

  typedef logic [PtrWidth-1:0]  ptr_t;
  typedef logic [FillWidth-1:0] fill_t;

  logic [FlitWidth-1:0] r_mem [Depth];
  ptr_t                 r_wptr, r_rptr;
  fill_t                r_fill;
  port_state_e          r_state;
  logic                 r_in_ready, r_out_valid, r_ack;
  logic [CntWidth-1:0]  r_fwd;

  logic        w_push, w_pop;
  fill_t       w_fill_next;
  ptr_t        w_wptr_next, w_rptr_next;
  port_state_e w_state_next;

  assign w_push = in_valid_i & r_in_ready;
  assign w_pop  = r_out_valid & out_ready_i;

  assign w_wptr_next = (r_wptr == ptr_t'(Depth - 1)) ? '0 : r_wptr + ptr_t'(1);
  assign w_rptr_next = (r_rptr == ptr_t'(Depth - 1)) ? '0 : r_rptr + ptr_t'(1);

  always_comb begin
    w_fill_next = r_fill;
    unique case ({w_push, w_pop})
      2'b10:   w_fill_next = r_fill + fill_t'(1);
      2'b01:   w_fill_next = r_fill - fill_t'(1);
      default: w_fill_next = r_fill;
    endcase
  end

  // A request with nothing left to drain goes straight to isolation, so the ack
  // lands one cycle after the last pop (or the cycle after the request if empty).
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StActive, StDrain: begin
        if (!isolate_req_i)          w_state_next = StActive;
        else if (w_fill_next == '0)  w_state_next = StIsolated;
        else                         w_state_next = StDrain;
      end
      StIsolated: begin
        if (!isolate_req_i) w_state_next = StActive;
      end
      default: w_state_next = StActive;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StActive;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_ack       <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_fill      <= '0;
      r_fwd       <= '0;
      r_mem       <= '{default: '0};
    end else begin
      r_state     <= w_state_next;
      r_in_ready  <= (w_state_next == StActive) && (w_fill_next != fill_t'(Depth));
      r_out_valid <= (w_state_next != StIsolated) && (w_fill_next != '0);
      r_ack       <= (w_state_next == StIsolated);
      r_fill      <= w_fill_next;
      if (w_push) begin
        r_mem[r_wptr] <= in_data_i;
        r_wptr        <= w_wptr_next;
      end
      if (w_pop) begin
        r_rptr <= w_rptr_next;
        r_fwd  <= r_fwd + CntWidth'(1);
      end
    end
  end

  assign in_ready_o    = r_in_ready;
  assign out_valid_o   = r_out_valid;
  assign out_data_o    = r_mem[r_rptr];
  assign isolate_ack_o = r_ack;
  assign fwd_cnt_o     = r_fwd;

endmodule

// File: rtl/floo_link_boundary.sv
// Tile-edge link stage: one independent buffered, isolatable port per direction.
// Ports share nothing; the top only slices the packed bundle per port.
module floo_link_boundary
  import floo_link_boundary_pkg::*;
#(
  parameter int unsigned NumPorts  = 4,
  parameter int unsigned FlitWidth = 64,
  parameter int unsigned Depth     = 2,
  parameter int unsigned CntWidth  = 16
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  floo_link_boundary_if.slave link
);

  if (!depth_ok(Depth)) begin : gen_depth_check
    $error("floo_link_boundary: Depth must be in 2..16");
  end

  logic [NumPorts-1:0]           w_in_ready, w_out_valid, w_ack;
  logic [NumPorts*FlitWidth-1:0] w_out_data;
  logic [NumPorts*CntWidth-1:0]  w_fwd_cnt;

  for (genvar p = 0; p < NumPorts; p++) begin : gen_port
    floo_link_port #(
      .FlitWidth (FlitWidth),
      .Depth     (Depth),
      .CntWidth  (CntWidth)
    ) u_port (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .in_valid_i    (link.in_valid_i[p]),
      .in_ready_o    (w_in_ready[p]),
      .in_data_i     (link.in_data_i[p*FlitWidth +: FlitWidth]),
      .out_valid_o   (w_out_valid[p]),
      .out_ready_i   (link.out_ready_i[p]),
      .out_data_o    (w_out_data[p*FlitWidth +: FlitWidth]),
      .isolate_req_i (link.isolate_req_i[p]),
      .isolate_ack_o (w_ack[p]),
      .fwd_cnt_o     (w_fwd_cnt[p*CntWidth +: CntWidth])
    );
  end

  assign link.in_ready_o    = w_in_ready;
  assign link.out_valid_o   = w_out_valid;
  assign link.out_data_o    = w_out_data;
  assign link.isolate_ack_o = w_ack;
  assign link.fwd_cnt_o     = w_fwd_cnt;

endmodule

// File: tb/tb_floo_link_boundary.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
// The model predicts every output each cycle from its own queues and isolation mode.
module tb_floo_link_boundary;
  import floo_link_boundary_pkg::*;

  localparam int unsigned NP = 4;
  localparam int unsigned FW = 16;
  localparam int unsigned D  = 2;
  localparam int unsigned CW = 4;

  localparam int MActive = 0;
  localparam int MDrain  = 1;
  localparam int MIso    = 2;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  floo_link_boundary_if #(.NumPorts(NP), .FlitWidth(FW), .CntWidth(CW)) bus ();

  floo_link_boundary #(
    .NumPorts  (NP),
    .FlitWidth (FW),
    .Depth     (D),
    .CntWidth  (CW)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .link   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [FW-1:0] m_q     [NP][$];
  int            m_mode  [NP];
  int unsigned   m_cnt   [NP];
  logic [FW-1:0] obs_log [NP][$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NP*FW-1:0] put(input int p, input logic [FW-1:0] v);
    logic [NP*FW-1:0] r;
    r = '0;
    r[p*FW +: FW] = v;
    return r;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_q[p].delete();
      obs_log[p].delete();
      m_mode[p] = MActive;
      m_cnt[p]  = 0;
    end
  endtask

  // Called just after a negedge: drive, check predictions, advance one clock.
  task automatic step(input logic [NP-1:0] vin, input logic [NP*FW-1:0] din,
                      input logic [NP-1:0] ordy, input logic [NP-1:0] req);
    logic [NP-1:0] push, pop;
    bus.in_valid_i    = vin;
    bus.in_data_i     = din;
    bus.out_ready_i   = ordy;
    bus.isolate_req_i = req;
    #1;
    for (int p = 0; p < NP; p++) begin
      logic e_rdy, e_vld, e_ack;
      e_rdy = (m_mode[p] == MActive) && (m_q[p].size() < D);
      e_vld = (m_mode[p] != MIso) && (m_q[p].size() > 0);
      e_ack = (m_mode[p] == MIso);
      check($sformatf("p%0d in_ready", p), 64'(bus.in_ready_o[p]), 64'(e_rdy));
      check($sformatf("p%0d out_valid", p), 64'(bus.out_valid_o[p]), 64'(e_vld));
      check($sformatf("p%0d isolate_ack", p), 64'(bus.isolate_ack_o[p]), 64'(e_ack));
      check($sformatf("p%0d fwd_cnt", p), 64'(bus.fwd_cnt_o[p*CW +: CW]),
            64'(m_cnt[p] % (1 << CW)));
      if (e_vld)
        check($sformatf("p%0d out_data", p), 64'(bus.out_data_o[p*FW +: FW]), 64'(m_q[p][0]));
      if (bus.out_valid_o[p] && ordy[p]) obs_log[p].push_back(bus.out_data_o[p*FW +: FW]);
      push[p] = vin[p] && e_rdy;
      pop[p]  = e_vld && ordy[p];
    end
    @(posedge clk_i);
    for (int p = 0; p < NP; p++) begin
      if (pop[p]) begin
        void'(m_q[p].pop_front());
        m_cnt[p] = (m_cnt[p] + 1) % (1 << CW);
      end
      if (push[p]) m_q[p].push_back(din[p*FW +: FW]);
      if (!req[p])                m_mode[p] = MActive;
      else if (m_mode[p] == MIso) m_mode[p] = MIso;
      else if (m_q[p].size() == 0) m_mode[p] = MIso;
      else                        m_mode[p] = MDrain;
    end
    @(negedge clk_i);
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    bus.in_valid_i = '0;
    bus.isolate_req_i = '0;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    bus.in_valid_i    = '0;
    bus.in_data_i     = '0;
    bus.out_ready_i   = '0;
    bus.isolate_req_i = '0;
    apply_reset();
    #1;
    check("reset in_ready", 64'(bus.in_ready_o), 64'hF);
    check("reset out_valid", 64'(bus.out_valid_o), 64'h0);
    check("reset fwd_cnt", 64'(bus.fwd_cnt_o), 64'h0);
    check("reset ack", 64'(bus.isolate_ack_o), 64'h0);
    @(negedge clk_i);

    // Port 1 stream of 8 flits, one cycle latency, one flit per cycle.
    for (int i = 0; i < 8; i++) begin
      step(4'b0010, put(1, FW'(16'h10 + i)), 4'b1111, 4'b0000);
      if (i == 0) begin
        check("stream first valid", 64'(bus.out_valid_o[1]), 64'h1);
        check("stream first data", 64'(bus.out_data_o[FW +: FW]), 64'h10);
      end
    end
    step(4'b0000, '0, 4'b1111, 4'b0000);
    step(4'b0000, '0, 4'b1111, 4'b0000);
    check("stream count", 64'(obs_log[1].size()), 64'd8);
    for (int i = 0; i < 8 && i < obs_log[1].size(); i++)
      check($sformatf("stream data %0d", i), 64'(obs_log[1][i]), 64'h10 + 64'(i));
    check("stream fwd_cnt1", 64'(bus.fwd_cnt_o[CW +: CW]), 64'd8);
    check("stream other fwd", 64'(bus.fwd_cnt_o & ~(64'hF << CW)), 64'h0);

    // Port 0 backpressure: third flit stalls, order preserved.
    step(4'b0001, put(0, 16'hA), 4'b0000, 4'b0000);
    step(4'b0001, put(0, 16'hB), 4'b0000, 4'b0000);
    check("bp full stall", 64'(bus.in_ready_o[0]), 64'h0);
    step(4'b0001, put(0, 16'hC), 4'b0000, 4'b0000);
    step(4'b0001, put(0, 16'hC), 4'b0001, 4'b0000);
    step(4'b0001, put(0, 16'hC), 4'b0001, 4'b0000);
    step(4'b0000, '0, 4'b0001, 4'b0000);
    step(4'b0000, '0, 4'b0001, 4'b0000);
    check("bp count", 64'(obs_log[0].size()), 64'd3);
    if (obs_log[0].size() == 3) begin
      check("bp order 0", 64'(obs_log[0][0]), 64'hA);
      check("bp order 1", 64'(obs_log[0][1]), 64'hB);
      check("bp order 2", 64'(obs_log[0][2]), 64'hC);
    end

    // Port 2 isolation with two flits held.
    step(4'b0100, put(2, 16'h21), 4'b0000, 4'b0000);
    step(4'b0100, put(2, 16'h22), 4'b0000, 4'b0000);
    step(4'b0000, '0, 4'b0100, 4'b0100);
    check("iso in_ready low", 64'(bus.in_ready_o[2]), 64'h0);
    check("iso no early ack", 64'(bus.isolate_ack_o[2]), 64'h0);
    step(4'b0000, '0, 4'b0100, 4'b0100);
    check("iso ack", 64'(bus.isolate_ack_o[2]), 64'h1);
    check("iso out_valid", 64'(bus.out_valid_o[2]), 64'h0);
    step(4'b0100, put(2, 16'h99), 4'b0100, 4'b0100);
    step(4'b0000, '0, 4'b0100, 4'b0000);
    check("iso release ready", 64'(bus.in_ready_o[2]), 64'h1);

    // Aborted isolation keeps data intact.
    obs_log[2].delete();
    step(4'b0100, put(2, 16'h31), 4'b0000, 4'b0000);
    step(4'b0100, put(2, 16'h32), 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++) step(4'b0000, '0, 4'b0000, 4'b0100);
    check("abort no ack", 64'(bus.isolate_ack_o[2]), 64'h0);
    step(4'b0000, '0, 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++) step(4'b0000, '0, 4'b0100, 4'b0000);
    check("abort count", 64'(obs_log[2].size()), 64'd2);
    if (obs_log[2].size() == 2) begin
      check("abort data 0", 64'(obs_log[2][0]), 64'h31);
      check("abort data 1", 64'(obs_log[2][1]), 64'h32);
    end

    // Counter wrap on port 3 after a fresh reset, then asynchronous reset mid-burst.
    apply_reset();
    for (int i = 0; i < 17; i++) step(4'b1000, put(3, FW'(i)), 4'b1000, 4'b0000);
    step(4'b0000, '0, 4'b1000, 4'b0000);
    check("wrap fwd_cnt3", 64'(bus.fwd_cnt_o[3*CW +: CW]), 64'd1);
    for (int i = 0; i < 3; i++) step(4'b1000, put(3, 16'h55), 4'b0000, 4'b0000);
    bus.in_valid_i = 4'b1000;
    #2;
    rst_ni = 1'b0;
    #1;
    check("async rst in_ready", 64'(bus.in_ready_o), 64'hF);
    check("async rst out_valid", 64'(bus.out_valid_o), 64'h0);
    check("async rst fwd_cnt", 64'(bus.fwd_cnt_o), 64'h0);
    check("async rst ack", 64'(bus.isolate_ack_o), 64'h0);
    apply_reset();

    // Random traffic with sticky, occasionally toggling isolation requests.
    begin
      logic [NP-1:0] req;
      req = '0;
      for (int c = 0; c < 2000; c++) begin
        for (int p = 0; p < NP; p++)
          if ($urandom_range(15) == 0) req[p] = ~req[p];
        step(NP'($urandom), {$urandom, $urandom}, NP'($urandom), req);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
